conv_layer_sequencer: RTL

- Controller that runs one convolution layer of NUM_FILT filters through the conv→ReLU→max-pool accelerator, one filter at a time.
- Per filter: fetches the kernel from weight memory, clears the accelerator, streams the n×n activation map from activation memory, then writes the pooled results to output memory.
- Sits between the layer memories and the accelerator datapath. Driven by a start/done handshake from the top-level control.

---
 rtl/conv_layer_sequencer_if.sv | 50 +++++
 rtl/conv_layer_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sequencer_if.sv
// Bus bundle between the conv layer sequencer and its environment:
// layer control handshake, layer memories and the accelerator datapath.
// master = sequencer side, slave = memories / accelerator / top control.
interface conv_layer_sequencer_if #(
    parameter int N  = 16,
    parameter int k  = 3,
    parameter int AW = 8,
    parameter int FW = 2,
    parameter int OW = 8
) ();
    // layer control
    logic               start;
    logic               busy;
    logic               done;
    logic               error;

    // activation memory
    logic               act_rd_en;
    logic [AW-1:0]      act_addr;

    // weight memory
    logic               wt_rd_en;
    logic [FW-1:0]      wt_addr;
    logic [k*k*N-1:0]   wt_data;

    // accelerator
    logic               acc_rst_n;
    logic               acc_ce;
    logic [k*k*N-1:0]   acc_weight;
    logic               acc_valid_op;
    logic               acc_end_op;
    logic [N-1:0]       acc_data_out;

    // output memory
    logic               out_wr_en;
    logic [OW-1:0]      out_addr;
    logic [N-1:0]       out_data;

    modport master (
        input  start, wt_data, acc_valid_op, acc_end_op, acc_data_out,
        output busy, done, error, act_rd_en, act_addr, wt_rd_en, wt_addr,
               acc_rst_n, acc_ce, acc_weight, out_wr_en, out_addr, out_data
    );

    modport slave (
        output start, wt_data, acc_valid_op, acc_end_op, acc_data_out,
        input  busy, done, error, act_rd_en, act_addr, wt_rd_en, wt_addr,
               acc_rst_n, acc_ce, acc_weight, out_wr_en, out_addr, out_data
    );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Convolution layer sequencer: runs NUM_FILT filters one at a time through
// the conv -> ReLU -> max-pool accelerator (kernel fetch, accelerator clear,
// n*n activation stream, pooled-output capture into output memory).
//
// Optional build macro: ACC_TIMEOUT_EN
//   defined   : DRAIN watchdog of TIMEOUT cycles; on expiry the layer is
//               aborted, sticky error is raised and done still pulses.
//   undefined : error tied to 0, DRAIN waits for all pooled outputs.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; accelerator held in reset
// WREQ    | weight read request for the current filter
// WLAT    | weight data returned, latched into acc_weight
// CLEAR   | clear activation / output counters, accelerator still reset
// STREAM  | issue n*n activation reads, capture pooled outputs
// DRAIN   | keep accelerator enabled until POOL_OUTS outputs captured
// NEXT    | advance to next filter or finish the layer
// DONE    | one-cycle done pulse
module conv_layer_sequencer #(
    parameter int N        = 16,
    parameter int n        = 6,
    parameter int k        = 3,
    parameter int p        = 2,
    parameter int NUM_FILT = 4,
    parameter int AW       = 8,
    parameter int FW       = 2,
    parameter int OW       = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic                   clk,
    input  logic                   global_rst,
    conv_layer_sequencer_if.master bus
);

    localparam int POOL_SIDE = (n - k + 1) / p;
    localparam int POOL_OUTS = POOL_SIDE * POOL_SIDE;
    localparam int OCW       = $clog2(POOL_OUTS + 1);
    localparam int AREA      = n * n;

    typedef enum logic [2:0] {
        S_IDLE, S_WREQ, S_WLAT, S_CLEAR, S_STREAM, S_DRAIN, S_NEXT, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [FW-1:0]      filt_q, filt_d;
    logic [AW-1:0]      act_cnt_q, act_cnt_d;
    logic [OCW-1:0]     out_cnt_q, out_cnt_d;
    logic [k*k*N-1:0]   acc_weight_q, acc_weight_d;
    logic               acc_ce_q, acc_ce_d;
    logic               out_wr_en_q, out_wr_en_d;
    logic [OW-1:0]      out_addr_q, out_addr_d;
    logic [N-1:0]       out_data_q, out_data_d;
    logic               wd_expire;
    logic               capture;
    logic               unused_ok;

    // a pooled output is accepted only while the accelerator is running and
    // the per-filter quota is not yet full; surplus outputs are dropped
    assign capture = ((state_q == S_STREAM) || (state_q == S_DRAIN))
                     && bus.acc_valid_op
                     && (out_cnt_q < OCW'(POOL_OUTS));

    // state and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!global_rst) begin
            state_q      <= S_IDLE;
            filt_q       <= '0;
            act_cnt_q    <= '0;
            out_cnt_q    <= '0;
            acc_weight_q <= '0;
            acc_ce_q     <= 1'b0;
            out_wr_en_q  <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            filt_q       <= filt_d;
            act_cnt_q    <= act_cnt_d;
            out_cnt_q    <= out_cnt_d;
            acc_weight_q <= acc_weight_d;
            acc_ce_q     <= acc_ce_d;
            out_wr_en_q  <= out_wr_en_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_WREQ;
            S_WREQ:   state_d = S_WLAT;
            S_WLAT:   state_d = S_CLEAR;
            S_CLEAR:  state_d = S_STREAM;
            S_STREAM: if (act_cnt_q == AW'(AREA - 1)) state_d = S_DRAIN;
            S_DRAIN: begin
                if (out_cnt_q == OCW'(POOL_OUTS)) state_d = S_NEXT;
                else if (wd_expire)               state_d = S_DONE;
            end
            S_NEXT: begin
                if (filt_q == FW'(NUM_FILT - 1)) state_d = S_DONE;
                else                             state_d = S_WREQ;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // counters, kernel latch and output-write capture
    always_comb begin
        filt_d       = filt_q;
        act_cnt_d    = act_cnt_q;
        out_cnt_d    = out_cnt_q;
        acc_weight_d = acc_weight_q;
        acc_ce_d     = (state_q == S_STREAM);
        out_wr_en_d  = 1'b0;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;

        case (state_q)
            S_IDLE:   if (bus.start) filt_d = '0;
            S_WLAT:   acc_weight_d = bus.wt_data;
            S_CLEAR: begin
                act_cnt_d = '0;
                out_cnt_d = '0;
            end
            S_STREAM: act_cnt_d = act_cnt_q + 1'b1;
            S_NEXT:   if (filt_q != FW'(NUM_FILT - 1)) filt_d = filt_q + 1'b1;
            default: ;
        endcase

        if (capture) begin
            out_wr_en_d = 1'b1;
            out_data_d  = bus.acc_data_out;
            out_addr_d  = OW'(filt_q) * OW'(POOL_OUTS) + OW'(out_cnt_q);
            out_cnt_d   = out_cnt_q + 1'b1;
        end
    end

    // state-decoded outputs
    always_comb begin
        bus.busy      = (state_q != S_IDLE);
        bus.done      = (state_q == S_DONE);
        bus.wt_rd_en  = (state_q == S_WREQ);
        bus.act_rd_en = (state_q == S_STREAM);
        bus.acc_rst_n = (state_q == S_STREAM) || (state_q == S_DRAIN) ||
                        (state_q == S_NEXT)   || (state_q == S_DONE);
    end

    // acc_ce lags act_rd_en by one cycle and is held high while draining
    assign bus.acc_ce     = acc_ce_q | (state_q == S_DRAIN);
    assign bus.act_addr   = act_cnt_q;
    assign bus.wt_addr    = filt_q;
    assign bus.acc_weight = acc_weight_q;
    assign bus.out_wr_en  = out_wr_en_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.out_data   = out_data_q;

`ifdef ACC_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd_q, wd_d;
    logic           error_q, error_d;

    assign wd_expire = (state_q == S_DRAIN) && (wd_q == WDW'(TIMEOUT - 1))
                       && (out_cnt_q < OCW'(POOL_OUTS));

    // watchdog counts DRAIN cycles; error is sticky until the next start
    always_comb begin
        wd_d    = '0;
        error_d = error_q;
        if (state_q == S_DRAIN)             wd_d    = wd_q + 1'b1;
        if ((state_q == S_IDLE) && bus.start) error_d = 1'b0;
        if (wd_expire)                      error_d = 1'b1;
    end

    // watchdog registers
    always_ff @(posedge clk) begin
        if (!global_rst) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            error_q <= error_d;
        end
    end

    assign bus.error = error_q;
    assign unused_ok = &{1'b0, bus.acc_end_op};
`else
    localparam logic [31:0] TIMEOUT_BITS = TIMEOUT;

    assign wd_expire = 1'b0;
    assign bus.error = 1'b0;
    assign unused_ok = &{1'b0, bus.acc_end_op, TIMEOUT_BITS[0]};
`endif

endmodule
